rca_seq_ctrl: RTL



---
 rtl/rca_seq_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: wide add/subtract sequenced byte-serially through one 8-bit ripple-carry slice
module rca_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*WORDS-1:0] op_a,
    input  logic [8*WORDS-1:0] op_b,
    input  logic               cin,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*WORDS-1:0] result,
    output logic               cout,
    output logic               overflow,
    output logic               busy
);
    localparam int W  = 8 * WORDS;
    localparam int IW = $clog2(WORDS) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            c_q, c_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            rdy_q, rdy_d;
    logic [7:0]      a_byte, b_byte;
    logic [8:0]      sum;

    // next-state, byte-slice arithmetic and result capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        a_byte  = '0;
        b_byte  = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IW'(i)) begin
                a_byte = a_q[i*8 +: 8];
                b_byte = b_q[i*8 +: 8];
            end
        end
        sum = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, c_q};
        case (state_q)
            IDLE: begin
                if (in_valid && rdy_q) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    c_d     = cin ^ sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IW'(i)) res_d[i*8 +: 8] = sum[7:0];
                end
                c_d   = sum[8];
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(WORDS - 1)) begin
                    cout_d  = sum[8];
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum[7] != a_q[W-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    // state and datapath registers, cleared asynchronously so no partial result survives reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = res_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
endmodule
